// File: rtl/loa_adder_rr_arbiter_if.sv
// rtl/loa_adder_rr_arbiter_if.sv - request/response bundle for the shared LOA adder arbiter
//
// Groups the NUM_REQ requester handshakes and the single consumer handshake.
//   req_valid_i  [NUM_REQ]        per-requester request valid
//   req_ready_o  [NUM_REQ]        per-requester accept (one-hot or zero)
//   req_add1_i   [NUM_REQ*WIDTH]  packed operand A, requester k at [k*WIDTH +: WIDTH]
//   req_add2_i   [NUM_REQ*WIDTH]  packed operand B, same packing
//   rsp_valid_o                   result register holds a valid result
//   rsp_ready_i                   consumer accepts the result
//   rsp_result_o [WIDTH+1]        sum
//   rsp_id_o     [ID_W]           requester that produced rsp_result_o
// With LOA_ARB_EXACT_BYPASS_EN defined, also:
//   req_exact_i  [NUM_REQ]        per-requester exact-sum select
//   rsp_exact_o                   mode used for rsp_result_o
// Modports: master = requesters/consumer side, slave = arbiter side.

interface loa_adder_rr_arbiter_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*WIDTH-1:0] req_add1_i;
    logic [NUM_REQ*WIDTH-1:0] req_add2_i;
    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [WIDTH:0]           rsp_result_o;
    logic [ID_W-1:0]          rsp_id_o;
`ifdef LOA_ARB_EXACT_BYPASS_EN
    logic [NUM_REQ-1:0]       req_exact_i;
    logic                     rsp_exact_o;

    modport master (
        output req_valid_i, req_add1_i, req_add2_i, req_exact_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_id_o, rsp_exact_o
    );

    modport slave (
        input  req_valid_i, req_add1_i, req_add2_i, req_exact_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_id_o, rsp_exact_o
    );
`else
    modport master (
        output req_valid_i, req_add1_i, req_add2_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_id_o
    );

    modport slave (
        input  req_valid_i, req_add1_i, req_add2_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, rsp_id_o
    );
`endif
endinterface

// File: rtl/loa_adder_rr_arbiter.sv
// rtl/loa_adder_rr_arbiter.sv - round-robin shared lower-part-OR approximate adder
//
// One WIDTH-bit LOA adder (OR in the low LOWER_WIDTH bits, generate/propagate
// carry logic in the upper bits) is shared by NUM_REQ requesters. A
// combinational round-robin grant picks one valid requester whenever the
// single-entry result slot is free; the sum is registered together with the
// requester index, giving one-cycle latency and one result per cycle.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     loa_adder_rr_arbiter_if.slave (request and response handshakes)
//
// Optional feature macro: LOA_ARB_EXACT_BYPASS_EN - adds per-requester
// req_exact_i selecting an exact a+b, and rsp_exact_o reporting the mode.

module loa_adder_rr_arbiter #(
    parameter int WIDTH       = 16,
    parameter int LOWER_WIDTH = 4,
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    loa_adder_rr_arbiter_if.slave        bus
);

    localparam int UW = WIDTH - LOWER_WIDTH;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [ID_W-1:0] rr_q;
    logic [WIDTH:0]  result_q;
    logic [ID_W-1:0] id_q;

    logic            slot_free;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] rr_next;
    logic            accept;
    logic [NUM_REQ-1:0] ready_vec;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH:0]     sum;

    // Low bits are OR-combined; the carry into the upper part is the AND of the
    // top approximate bits. The upper part uses generate/propagate carries and
    // keeps the final carry-out as the result MSB.
    function automatic logic [WIDTH:0] loa_sum(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [UW-1:0] g;
        logic [UW-1:0] p;
        logic [UW:0]   c;
        g    = a[WIDTH-1:LOWER_WIDTH] & b[WIDTH-1:LOWER_WIDTH];
        p    = a[WIDTH-1:LOWER_WIDTH] ^ b[WIDTH-1:LOWER_WIDTH];
        c    = '0;
        c[0] = a[LOWER_WIDTH-1] & b[LOWER_WIDTH-1];
        for (int i = 0; i < UW; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[UW], p ^ c[UW-1:0], a[LOWER_WIDTH-1:0] | b[LOWER_WIDTH-1:0]};
    endfunction

    // The slot can take a new result when empty, or when the consumer drains
    // the current one in this same cycle.
    assign slot_free = (state_q == EMPTY) || bus.rsp_ready_i;

    // Round-robin search starting at rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && bus.req_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    // rst_ni gates the grant so no requester sees an accept during reset.
    assign accept = grant_found && slot_free && rst_ni;

    always_comb begin
        ready_vec = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            ready_vec[k] = accept && (grant_id == ID_W'(k));
        end
    end

    assign bus.req_ready_o = ready_vec;

    assign rr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // Operand select for the granted requester.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                op_a = bus.req_add1_i[k*WIDTH +: WIDTH];
                op_b = bus.req_add2_i[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef LOA_ARB_EXACT_BYPASS_EN
    logic exact_sel;
    logic exact_q;

    always_comb begin
        exact_sel = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                exact_sel = bus.req_exact_i[k];
            end
        end
    end

    assign sum = exact_sel ? ({1'b0, op_a} + {1'b0, op_b}) : loa_sum(op_a, op_b);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exact_q <= 1'b0;
        end else if (accept) begin
            exact_q <= exact_sel;
        end
    end

    assign bus.rsp_exact_o = exact_q;
`else
    assign sum = loa_sum(op_a, op_b);
`endif

    // Output slot FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (bus.rsp_ready_i && !accept) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Result register and priority pointer only move on an accept; a drained
    // slot keeps its last contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q <= '0;
            id_q     <= '0;
            rr_q     <= '0;
        end else if (accept) begin
            result_q <= sum;
            id_q     <= grant_id;
            rr_q     <= rr_next;
        end
    end

    assign bus.rsp_valid_o  = (state_q == FULL);
    assign bus.rsp_result_o = result_q;
    assign bus.rsp_id_o     = id_q;

endmodule
